// File: rtl/copiador_hd_mem_instr.sv
// rtl/copiador_hd_mem_instr.sv - copies a program image word by word from the HD into instruction memory.
// Optional feature: CHECKSUM_EN adds a running checksum output of the written words.
module copiador_hd_mem_instr #(
  parameter int LARGURA_DADO = 32,
  parameter int HD_LATENCIA  = 1,
  parameter int MAX_PALAVRAS = 500
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iniciar,
  input  logic                    abortar,
  input  logic [4:0]              indiceProgramaIn,
  input  logic [4:0]              setorIn,
  input  logic [15:0]             trilhaInicio,
  input  logic [15:0]             quantidade,
  input  logic [LARGURA_DADO-1:0] dadoHD,
  output logic [4:0]              setor,
  output logic [31:0]             trilha,
  output logic [4:0]              indicePrograma,
  output logic [15:0]             enderecoEscritaMemInstr,
  output logic                    lerHD,
  output logic                    escreveMemInstr,
  output logic [LARGURA_DADO-1:0] dadoMemInstr,
  output logic                    ocupado,
  output logic                    concluido,
  output logic                    erro
`ifdef CHECKSUM_EN
  ,
  output logic [LARGURA_DADO-1:0] checksum
`endif
);

  typedef enum logic [2:0] {OCIOSO, LER, ESPERA, ESCREVER, FIM} estado_t;

  localparam logic [2:0]  LAT_FIM = 3'(HD_LATENCIA - 1);
  localparam logic [15:0] MAX_Q   = 16'(MAX_PALAVRAS);

  estado_t                 state_q, state_d;
  logic [15:0]             i_q, quant_q, base_q, trilha_q, endr_q;
  logic [4:0]              slot_q, setor_q, indice_q;
  logic [2:0]              lat_q;
  logic [LARGURA_DADO-1:0] dado_q;
  logic                    erro_q;

  logic [16:0] fim_trilha;
  logic        pedido, rejeita, aceita;
  logic [15:0] i_mais;

  assign fim_trilha = {1'b0, trilhaInicio} + {1'b0, quantidade};
  assign rejeita    = (quantidade > MAX_Q) || (fim_trilha > 17'h10000);
  // abortar in OCIOSO silently drops a simultaneous start request
  assign pedido     = (state_q == OCIOSO) && iniciar && !abortar;
  assign aceita     = pedido && !rejeita;
  assign i_mais     = i_q + 16'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:   if (aceita) state_d = (quantidade == 16'd0) ? FIM : LER;
      LER:      state_d = ESPERA;
      ESPERA:   if (lat_q == LAT_FIM) state_d = ESCREVER;
      ESCREVER: state_d = (i_mais == quant_q) ? FIM : LER;
      FIM:      state_d = OCIOSO;
      default:  state_d = OCIOSO;
    endcase
    if (abortar) state_d = OCIOSO;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= OCIOSO;
      i_q      <= '0;
      quant_q  <= '0;
      base_q   <= '0;
      trilha_q <= '0;
      endr_q   <= '0;
      slot_q   <= '0;
      setor_q  <= '0;
      indice_q <= '0;
      lat_q    <= '0;
      dado_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      erro_q  <= pedido && rejeita;
      if (aceita) begin
        slot_q  <= indiceProgramaIn;
        setor_q <= setorIn;
        base_q  <= trilhaInicio;
        quant_q <= quantidade;
        i_q     <= '0;
        lat_q   <= '0;
        if (state_d == LER) trilha_q <= trilhaInicio;
      end
      if (state_q == ESPERA) begin
        if (lat_q == LAT_FIM) begin
          dado_q <= dadoHD;
          lat_q  <= '0;
        end else begin
          lat_q <= lat_q + 3'd1;
        end
      end
      if (state_q == ESPERA && state_d == ESCREVER) begin
        indice_q <= slot_q;
        endr_q   <= i_q;
      end
      if (state_q == ESCREVER) i_q <= i_mais;
      // trilha only moves when another read follows, so it holds after the last word
      if (state_q == ESCREVER && state_d == LER) trilha_q <= base_q + i_mais;
    end
  end

`ifdef CHECKSUM_EN
  logic [LARGURA_DADO-1:0] soma_q;

  always_ff @(posedge clock) begin
    if (reset || aceita) soma_q <= '0;
    else if (state_q == ESCREVER) soma_q <= soma_q + dado_q;
  end

  assign checksum = soma_q;
`endif

  assign setor                   = setor_q;
  assign trilha                  = {16'b0, trilha_q};
  assign indicePrograma          = indice_q;
  assign enderecoEscritaMemInstr = endr_q;
  assign lerHD                   = (state_q == LER);
  assign escreveMemInstr         = (state_q == ESCREVER);
  assign dadoMemInstr            = dado_q;
  assign ocupado                 = (state_q != OCIOSO);
  assign concluido               = (state_q == FIM);
  assign erro                    = erro_q;

endmodule

// File: tb/tb_copiador_hd_mem_instr.sv
// tb/tb_copiador_hd_mem_instr.sv - scoreboard bench running HD_LATENCIA=1 and =3 copies side by side.
module tb_copiador_hd_mem_instr;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset, iniciar, abortar;
  logic [4:0]    indiceProgramaIn, setorIn;
  logic [15:0]   trilhaInicio, quantidade;
  logic [W-1:0]  dadoHD [2];
  logic [4:0]    setor_o [2];
  logic [31:0]   trilha_o [2];
  logic [4:0]    indice_o [2];
  logic [15:0]   endr_o [2];
  logic          ler_o [2], esc_o [2], ocup_o [2], conc_o [2], erro_o [2];
  logic [W-1:0]  dmem_o [2];
`ifdef CHECKSUM_EN
  logic [W-1:0]  csum_o [2];
`endif

  logic [63:0] rq0[$], rq1[$], wq0[$], wq1[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, rel_m;
  int nread[2], nwrite[2], nconc[2], nerr[2], nbusy[2], exp_lat[2];
  logic [W-1:0] hd_ofs, exp_sum;
  bit sb_on;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // HD model: the word for the strobed track is held until the next read
  always @(posedge clock) begin
    if (ler_o[0]) dadoHD[0] <= trilha_o[0] + hd_ofs;
    if (ler_o[1]) dadoHD[1] <= trilha_o[1] + hd_ofs;
  end

  copiador_hd_mem_instr #(.LARGURA_DADO(W), .HD_LATENCIA(1), .MAX_PALAVRAS(500)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .indiceProgramaIn(indiceProgramaIn), .setorIn(setorIn), .trilhaInicio(trilhaInicio),
    .quantidade(quantidade), .dadoHD(dadoHD[0]), .setor(setor_o[0]), .trilha(trilha_o[0]),
    .indicePrograma(indice_o[0]), .enderecoEscritaMemInstr(endr_o[0]), .lerHD(ler_o[0]),
    .escreveMemInstr(esc_o[0]), .dadoMemInstr(dmem_o[0]), .ocupado(ocup_o[0]),
    .concluido(conc_o[0]), .erro(erro_o[0])
`ifdef CHECKSUM_EN
    , .checksum(csum_o[0])
`endif
  );

  copiador_hd_mem_instr #(.LARGURA_DADO(W), .HD_LATENCIA(3), .MAX_PALAVRAS(500)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .indiceProgramaIn(indiceProgramaIn), .setorIn(setorIn), .trilhaInicio(trilhaInicio),
    .quantidade(quantidade), .dadoHD(dadoHD[1]), .setor(setor_o[1]), .trilha(trilha_o[1]),
    .indicePrograma(indice_o[1]), .enderecoEscritaMemInstr(endr_o[1]), .lerHD(ler_o[1]),
    .escreveMemInstr(esc_o[1]), .dadoMemInstr(dmem_o[1]), .ocupado(ocup_o[1]),
    .concluido(conc_o[1]), .erro(erro_o[1])
`ifdef CHECKSUM_EN
    , .checksum(csum_o[1])
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return rq0.size();
      1: return rq1.size();
      2: return wq0.size();
      default: return wq1.size();
    endcase
  endfunction

  function automatic logic [63:0] qpop(input int k);
    case (k)
      0: return rq0.pop_front();
      1: return rq1.pop_front();
      2: return wq0.pop_front();
      default: return wq1.pop_front();
    endcase
  endfunction

  task automatic qpush(input int k, input logic [63:0] v);
    case (k)
      0: rq0.push_back(v);
      1: rq1.push_back(v);
      2: wq0.push_back(v);
      default: wq1.push_back(v);
    endcase
  endtask

  always @(negedge clock) begin
    if (!reset && sb_on) begin
      rel_m = cyc - start_cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (ocup_o[d]) nbusy[d]++;
        if (ler_o[d]) begin
          nread[d]++;
          if (qsize(d) == 0) check("ler_extra", 64'd1, 64'd0);
          else check("ler_addr", 64'({setor_o[d], trilha_o[d]}), qpop(d));
        end
        if (esc_o[d]) begin
          nwrite[d]++;
          if (qsize(2 + d) == 0) check("write_extra", 64'd1, 64'd0);
          else check("write", 64'({indice_o[d], endr_o[d], dmem_o[d]}), qpop(2 + d));
        end
        if (conc_o[d]) begin
          nconc[d]++;
          check("conc_lat", 64'(rel_m), 64'(exp_lat[d]));
`ifdef CHECKSUM_EN
          check("checksum", 64'(csum_o[d]), 64'(exp_sum));
`endif
        end
        if (erro_o[d]) begin
          nerr[d]++;
          check("erro_lat", 64'(rel_m), 64'd1);
        end
      end
    end
  end

  task automatic run(input logic [4:0] slot, input logic [4:0] sec, input logic [15:0] t0,
                     input logic [15:0] q, input bit exp_err, input int abort_rel, input bit poke);
    int lat, nb[2], nc[2], ne[2], expc[2];
    logic [W-1:0] word;
    bit done;
    exp_sum = '0;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      exp_lat[d] = int'(q) * (lat + 2) + 1;
      nb[d] = nbusy[d]; nc[d] = nconc[d]; ne[d] = nerr[d];
      expc[d] = (!exp_err && (abort_rel == 0 || abort_rel >= exp_lat[d])) ? 1 : 0;
      if (!exp_err) begin
        for (int j = 0; j < int'(q); j++) begin
          word = 32'(t0 + 16'(j)) + hd_ofs;
          if (d == 0) exp_sum = exp_sum + word;
          if (abort_rel == 0 || j * (lat + 2) + 1 <= abort_rel)
            qpush(d, 64'({sec, 16'b0, t0 + 16'(j)}));
          if (abort_rel == 0 || (j + 1) * (lat + 2) <= abort_rel)
            qpush(2 + d, 64'({slot, 16'(j), word}));
        end
      end
    end
    @(negedge clock);
    indiceProgramaIn = slot; setorIn = sec; trilhaInicio = t0; quantidade = q; iniciar = 1'b1;
    @(posedge clock); #1;
    start_cyc = cyc;
    iniciar = 1'b0;
    if (poke) begin
      repeat (4) @(posedge clock);
      #1 iniciar = 1'b1; trilhaInicio = 16'h0300; quantidade = 16'd1; indiceProgramaIn = 5'd9;
      @(posedge clock);
      #1 iniciar = 1'b0;
    end
    if (abort_rel > 0) begin
      repeat (abort_rel - 1) @(posedge clock);
      #1 abortar = 1'b1;
      @(posedge clock);
      #1 abortar = 1'b0;
      check("abort_idle", 64'({ocup_o[0], ocup_o[1]}), 64'd0);
    end
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clock);
      if (t >= 1 && !ocup_o[0] && !ocup_o[1]) done = 1'b1;
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("reads_left", 64'(qsize(d)), 64'd0);
      check("writes_left", 64'(qsize(2 + d)), 64'd0);
      check("conc_count", 64'(nconc[d] - nc[d]), 64'(expc[d]));
      check("erro_count", 64'(nerr[d] - ne[d]), 64'(exp_err));
      if (abort_rel == 0)
        check("busy_cycles", 64'(nbusy[d] - nb[d]), exp_err ? 64'd0 : 64'(exp_lat[d]));
    end
    rq0.delete(); rq1.delete(); wq0.delete(); wq1.delete();
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; sb_on = 1'b1;
    indiceProgramaIn = '0; setorIn = '0; trilhaInicio = '0; quantidade = '0;
    hd_ofs = 32'hA000; exp_sum = '0;
    for (int d = 0; d < 2; d++) begin
      nread[d] = 0; nwrite[d] = 0; nconc[d] = 0; nerr[d] = 0; nbusy[d] = 0; exp_lat[d] = 0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("reset_outs", 64'({setor_o[d], trilha_o[d], indice_o[d], endr_o[d], ler_o[d],
                                esc_o[d], ocup_o[d], conc_o[d], erro_o[d]}), 64'd0);
      check("reset_dmem", 64'(dmem_o[d]), 64'd0);
    end

    run(5'd2, 5'd0, 16'd100, 16'd3, 1'b0, 0, 1'b0);
    run(5'd1, 5'd3, 16'd16, 16'd0, 1'b0, 0, 1'b0);
    run(5'd4, 5'd1, 16'd10, 16'd501, 1'b1, 0, 1'b0);
    run(5'd4, 5'd1, 16'hFFFF, 16'd2, 1'b1, 0, 1'b0);
    run(5'd7, 5'd2, 16'hFFFF, 16'd1, 1'b0, 0, 1'b0);
    run(5'd3, 5'd5, 16'd200, 16'd5, 1'b0, 8, 1'b0);
    run(5'd6, 5'd4, 16'd50, 16'd1, 1'b0, 0, 1'b0);

    @(negedge clock);
    iniciar = 1'b1; abortar = 1'b1; quantidade = 16'd2; trilhaInicio = 16'd5;
    @(posedge clock); #1;
    iniciar = 1'b0; abortar = 1'b0;
    check("start_dropped", 64'({ocup_o[0], ocup_o[1], erro_o[0], erro_o[1]}), 64'd0);

    hd_ofs = 32'd1;
    run(5'd8, 5'd6, 16'd0, 16'd3, 1'b0, 0, 1'b1);
    hd_ofs = 32'hA000;

    sb_on = 1'b0;
    @(negedge clock);
    trilhaInicio = 16'd40; quantidade = 16'd5; iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++)
      check("reset_mid", 64'({setor_o[d], trilha_o[d], indice_o[d], endr_o[d], ler_o[d],
                               esc_o[d], ocup_o[d], conc_o[d], erro_o[d]}) | 64'(dmem_o[d]), 64'd0);
    reset = 1'b0;
    sb_on = 1'b1;

    run(5'd31, 5'd31, 16'hFE0C, 16'd500, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
